// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: INIT -> IF -> ID -> (LS -> WB) -> IF, with HALT/ERR sinks and cycle/instret counters.
// Latency: one state per clock; IF and LS stretch until the memory acks or the wait counter expires.
// Backpressure: imem_req/dmem_req are held until the matching rvalid; a missing ack past TIMEOUT cycles lands in ERR.
module multicycle_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_is_load,
    input  logic             inst_is_store,
    input  logic             inst_halt,
    output logic             imem_req,
    input  logic             imem_rvalid,
    output logic             dmem_req,
    output logic             dmem_wen,
    input  logic             dmem_rvalid,
    output logic             reg_write,
    output logic             pc_update,
    output logic [2:0]       state_o,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_INIT = 3'b000,
        S_IF   = 3'b001,
        S_ID   = 3'b011,
        S_LS   = 3'b010,
        S_WB   = 3'b110,
        S_HALT = 3'b100,
        S_ERR  = 3'b111
    } state_t;

    // Last wait-counter value that may still be waited through; TIMEOUT=0 disables the check.
    localparam logic [TO_W-1:0] TO_LIM = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit              TO_EN  = (TIMEOUT != 0);

    state_t            r_state;
    state_t            w_next;
    logic [TO_W-1:0]   r_wait;
    logic [TO_W-1:0]   w_wait_nxt;
    logic              r_is_store;
    logic              w_is_store_nxt;
    logic              w_reg_write;
    logic              w_pc_update;
    logic              w_to_hit;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_instret;

    // Expiry only matters in a cycle that has no ack; the ack always wins in the limit cycle.
    assign w_to_hit = TO_EN && (r_wait == TO_LIM);

    // Next-state, Mealy strobes and wait-counter update; counter is zero whenever we are outside IF/LS,
    // so it is already clear on every entry to IF or LS.
    always_comb begin
        w_next         = r_state;
        w_wait_nxt     = '0;
        w_is_store_nxt = r_is_store;
        w_reg_write    = 1'b0;
        w_pc_update    = 1'b0;
        case (r_state)
            S_INIT: w_next = S_IF;
            S_IF: begin
                if (imem_rvalid) begin
                    w_next = S_ID;
                end else if (w_to_hit) begin
                    w_next = S_ERR;
                end else begin
                    w_wait_nxt = r_wait + TO_W'(1);
                end
            end
            S_ID: begin
                if (inst_halt) begin
                    w_next = S_HALT;
                end else if (inst_is_load && inst_is_store) begin
                    w_next = S_ERR;
                end else if (inst_is_load) begin
                    w_next         = S_LS;
                    w_is_store_nxt = 1'b0;
                end else if (inst_is_store) begin
                    w_next         = S_LS;
                    w_is_store_nxt = 1'b1;
                end else begin
                    w_reg_write = 1'b1;
                    w_pc_update = 1'b1;
                    w_next      = S_IF;
                end
            end
            S_LS: begin
                if (dmem_rvalid) begin
                    if (r_is_store) begin
                        // Stores retire on the ack itself; nothing to write back.
                        w_pc_update = 1'b1;
                        w_next      = S_IF;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_to_hit) begin
                    w_next = S_ERR;
                end else begin
                    w_wait_nxt = r_wait + TO_W'(1);
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_pc_update = 1'b1;
                w_next      = S_IF;
            end
            S_HALT: w_next = S_HALT;
            S_ERR:  w_next = S_ERR;
            default: w_next = S_INIT;
        endcase
    end

    // State, wait counter and latched load/store direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_wait     <= '0;
            r_is_store <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait     <= w_wait_nxt;
            r_is_store <= w_is_store_nxt;
        end
    end

    // Free-running cycle counter (frozen in HALT/ERR) and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            if (r_state != S_HALT && r_state != S_ERR) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (w_pc_update) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    // Requests and status are pure decodes of the state register, so reset drops them at once.
    assign imem_req    = (r_state == S_IF);
    assign dmem_req    = (r_state == S_LS);
    assign dmem_wen    = (r_state == S_LS) && r_is_store;
    assign halted      = (r_state == S_HALT);
    assign timeout_err = (r_state == S_ERR);
    assign state_o     = r_state;
    assign reg_write   = w_reg_write;
    assign pc_update   = w_pc_update;
    assign cycle_cnt   = r_cycle_cnt;
    assign instret     = r_instret;

endmodule
